// File: rtl/ram_arbiter_128x8_if.sv
// ram_arbiter_128x8_if: core and DMA request/grant/data bundle; master drives requests, slave returns grants and read data
interface ram_arbiter_128x8_if;
  logic       core_req;
  logic       core_we;
  logic [6:0] core_addr;
  logic [7:0] core_wdata;
  logic       core_gnt;
  logic [7:0] core_rdata;
  logic       dma_req;
  logic       dma_we;
  logic [6:0] dma_addr;
  logic [7:0] dma_wdata;
  logic       dma_gnt;
  logic [7:0] dma_rdata;
  logic       dma_rvalid;
  modport master (
    output core_req, core_we, core_addr, core_wdata, dma_req, dma_we, dma_addr, dma_wdata,
    input  core_gnt, core_rdata, dma_gnt, dma_rdata, dma_rvalid
  );
  modport slave (
    input  core_req, core_we, core_addr, core_wdata, dma_req, dma_we, dma_addr, dma_wdata,
    output core_gnt, core_rdata, dma_gnt, dma_rdata, dma_rvalid
  );
endinterface

// File: rtl/ram_arbiter_128x8.sv
// ram_arbiter_128x8: core-priority 128x8 RAM arbiter with DMA anti-starvation and post-reset clear; ports clk, rst, bus (core/DMA), ram_addr/ram_data/ram_en/ram_q, init_busy
module ram_arbiter_128x8 #(
  parameter int STARVE_LIMIT   = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  ram_arbiter_128x8_if.slave         bus,
  output logic [6:0]                 ram_addr,
  output logic [7:0]                 ram_data,
  output logic                       ram_en,
  input  logic [7:0]                 ram_q,
  output logic                       init_busy
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t     state, state_d;
  logic [6:0] clr_cnt;
  logic [3:0] starve_cnt;
  logic       run, clr, force_dma, core_gnt, dma_gnt;
  always_comb begin
    run       = (state == RUN) && !rst;
    clr       = (state == CLEAR) && !rst;
    force_dma = starve_cnt == 4'(STARVE_LIMIT);
    core_gnt  = run & bus.core_req & ~force_dma;
    dma_gnt   = run & bus.dma_req & (~bus.core_req | force_dma);
    state_d   = (state == CLEAR && &clr_cnt) ? RUN : state;
    ram_addr  = clr ? clr_cnt : core_gnt ? bus.core_addr : dma_gnt ? bus.dma_addr : 7'd0;
    ram_data  = core_gnt ? bus.core_wdata : dma_gnt ? bus.dma_wdata : 8'd0;
    ram_en    = clr | (core_gnt & bus.core_we) | (dma_gnt & bus.dma_we);
    init_busy = rst ? CLEAR_ON_RESET : state == CLEAR;
  end
  assign bus.core_gnt   = core_gnt;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.core_rdata = ram_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_cnt        <= 7'd0;
      starve_cnt     <= 4'd0;
      bus.dma_rvalid <= 1'b0;
      bus.dma_rdata  <= 8'd0;
    end else begin
      state          <= state_d;
      clr_cnt        <= clr ? clr_cnt + 7'd1 : clr_cnt;
      // a pending DMA request that loses implies core_req is also high
      starve_cnt     <= (!run || dma_gnt || !bus.dma_req) ? 4'd0 :
                        (starve_cnt != 4'(STARVE_LIMIT)) ? starve_cnt + 4'd1 : starve_cnt;
      bus.dma_rvalid <= dma_gnt & ~bus.dma_we;
      if (dma_gnt && !bus.dma_we) bus.dma_rdata <= ram_q;
    end
  end
endmodule
